code_classifier: RTL and testbench
==================================

// Module: code_classifier
// PURPOSE
//  Downstream consumer of the 64-bit spike code word from the `code` stage (CSNN classification path).
//  Scores each captured code against NUM_CLASS fixed 64-bit class templates (XNOR match count).
//  Accumulates scores over NUM_FRAMES consecutive code words, then reports the argmax class.
//  Scoring is serial, one class per cycle.
// PARAMETERS
//  NUM_CLASS   4                  number of classes, >=2; class_id width = CLS_W = clog2(NUM_CLASS)
//  NUM_FRAMES  8                  code words accumulated per decision, >=1
//  TEMPLATES   {4{64'h0}}         NUM_CLASS*64-bit packed templates; class k = TEMPLATES[64*k +: 64]
//  Score width is a localparam: SCORE_W = clog2(NUM_FRAMES*64+1), 10 at defaults. It never overflows.
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  clr          in   1        synchronous abort: drop partial accumulation, return to IDLE
//  code_valid   in   1        code word present
//  code         in   64       spike code word from the `code` stage
//  code_ready   out  1        block accepts a word this cycle
//  busy         out  1        high in any state other than IDLE
//  class_id     out  CLS_W    winning class of the last decision; held until the next decision
//  class_valid  out  1        one-cycle pulse when class_id is updated
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; all scores, frame_cnt, cls_idx, code_r, class_id and class_valid = 0.
//   - code_ready=1 once rst_n releases.
//  Accept:
//   - A word is accepted on a rising edge with code_valid & code_ready & !clr. It is captured in code_r.
//   - code_ready = (state==IDLE); it is combinational from state.
//  FSM states:
//   - IDLE: accept -> SCORE with cls_idx=0.
//   - SCORE: each cycle, score[cls_idx] += popcount(~(code_r ^ tmpl[cls_idx])), a value from 0 to 64.
//     Then cls_idx++. At cls_idx==NUM_CLASS-1:
//       * if frame_cnt==NUM_FRAMES-1 -> DECIDE.
//       * else frame_cnt++ -> IDLE.
//   - DECIDE: one cycle.
//     * Argmax over the scores; on a tie the lowest index wins.
//     * Registered into class_id, with class_valid=1 for the next cycle only.
//     * All scores, frame_cnt and cls_idx are cleared; -> IDLE.
//  Timing for a word accepted at edge t:
//   - Score updates occur at edges t+1 .. t+NUM_CLASS.
//   - code_ready is high again after edge t+NUM_CLASS.
//   - On the final frame: DECIDE occupies the cycle after edge t+NUM_CLASS; class_valid is high after edge t+NUM_CLASS+1.
//   - Max throughput is one word per NUM_CLASS+1 cycles (NUM_CLASS+2 on the final frame).
//  Back-pressure: code_valid while code_ready=0 is ignored. The upstream holds the word; nothing is lost or duplicated.
//  clr (any state):
//   - Next state is IDLE; scores, frame_cnt and cls_idx are cleared.
//   - No class_valid pulse. class_id keeps its previous value.
//   - clr together with code_valid in IDLE: clr wins and the word is not accepted.
//   - clr in DECIDE: the decision is discarded.
//  rst_n mid-operation: immediate return to the reset values above. No pulse is emitted.
//  class_valid is never high for two consecutive cycles.
// TESTING
//  Test templates: T0=64'h0, T1=64'hFFFFFFFFFFFFFFFF, T2=64'h00000000FFFFFFFF, T3=64'hFFFFFFFF00000000.
//  1. Reset check:
//     - Hold rst_n=0 for 1000ns with code_valid=0.
//     - Require class_id=0, class_valid=0 and busy=0.
//     - After release, require code_ready=1.
//  2. Single decision:
//     - Feed 8 words of all-ones, with code_valid held high.
//     - Require final scores {0,512,256,256}, one class_valid pulse and class_id=1.
//     - Require words accepted exactly 5 cycles apart.
//  3. Tie-break:
//     - Feed 8 words of 64'h0000FFFFFFFF0000, giving all scores 256.
//     - Require class_id=0.
//     - Repeat with 64'h00000000FFFFFFFF, giving scores {256,256,512,0}; require class_id=2.
//  4. clr abort:
//     - Feed 5 words of all-ones, then pulse clr.
//     - Then feed 8 words of 64'hFFFFFFFF00000000.
//     - Require no pulse after the abort and class_id=3, proving no residue from the 5 aborted words.
//  5. Back-pressure:
//     - Keep code_valid=1 and change code every cycle.
//     - Require only words presented while code_ready=1 are scored; check against a reference model.
//  6. Async reset mid-SCORE:
//     - Drop rst_n for 1 cycle during frame 3.
//     - Require immediate outputs=0 and no pulse.
//     - Require the next 8 words to produce a correct decision.

Source files
------------

// File: rtl/code_classifier.sv
// Scores 64-bit spike code words against fixed class templates by XNOR match count,
// accumulates over NUM_FRAMES words and reports the argmax class.
module code_classifier #(
  parameter int NUM_CLASS = 4,
  parameter int NUM_FRAMES = 8,
  parameter logic [NUM_CLASS*64-1:0] TEMPLATES = {NUM_CLASS{64'h0}},
  localparam int CLS_W = $clog2(NUM_CLASS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             code_valid,
  input  logic [63:0]      code,
  output logic             code_ready,
  output logic             busy,
  output logic [CLS_W-1:0] class_id,
  output logic             class_valid
);

  localparam int SCORE_W = $clog2(NUM_FRAMES * 64 + 1);
  localparam int FRM_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NUM_CLASS - 1);
  localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, SCORE, DECIDE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SCORE_W-1:0] scores [NUM_CLASS];
  logic [FRM_W-1:0]   frame_cnt;
  logic [CLS_W-1:0]   cls_idx;
  logic [63:0]        code_r;
  logic [63:0]        match_vec;
  logic [6:0]         match_cnt;
  logic [CLS_W-1:0]   best_idx;
  logic [SCORE_W-1:0] best_score;

  assign code_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (code_valid) state_nxt = SCORE;
      SCORE:   if (cls_idx == LAST_CLS) state_nxt = (frame_cnt == LAST_FRM) ? DECIDE : IDLE;
      DECIDE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // Match count of the captured word against the template currently being scored
  always_comb begin
    match_vec = ~(code_r ^ TEMPLATES[64*cls_idx +: 64]);
    match_cnt = '0;
    for (int b = 0; b < 64; b++) match_cnt = match_cnt + 7'(match_vec[b]);
  end

  // Strict greater-than keeps the lowest index on ties
  always_comb begin
    best_idx   = '0;
    best_score = scores[0];
    for (int k = 1; k < NUM_CLASS; k++) begin
      if (scores[k] > best_score) begin
        best_score = scores[k];
        best_idx   = CLS_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CLASS; k++) scores[k] <= '0;
      frame_cnt   <= '0;
      cls_idx     <= '0;
      code_r      <= '0;
      class_id    <= '0;
      class_valid <= 1'b0;
    end else begin
      class_valid <= 1'b0;
      if (clr) begin
        for (int k = 0; k < NUM_CLASS; k++) scores[k] <= '0;
        frame_cnt <= '0;
        cls_idx   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (code_valid) begin
              code_r  <= code;
              cls_idx <= '0;
            end
          end
          SCORE: begin
            scores[cls_idx] <= scores[cls_idx] + SCORE_W'(match_cnt);
            if (cls_idx == LAST_CLS) begin
              cls_idx <= '0;
              if (frame_cnt != LAST_FRM) frame_cnt <= frame_cnt + FRM_W'(1);
            end else begin
              cls_idx <= cls_idx + CLS_W'(1);
            end
          end
          DECIDE: begin
            class_id    <= best_idx;
            class_valid <= 1'b1;
            for (int k = 0; k < NUM_CLASS; k++) scores[k] <= '0;
            frame_cnt <= '0;
            cls_idx   <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_code_classifier.sv
// Directed bench for code_classifier: a per-cycle reference model predicts
// handshake, pulse timing, scores and decisions; explicit constants pin the key results.
module tb_code_classifier;

  localparam logic [63:0] T0 = 64'h0;
  localparam logic [63:0] T1 = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] T2 = 64'h00000000FFFFFFFF;
  localparam logic [63:0] T3 = 64'hFFFFFFFF00000000;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        code_valid;
  logic [63:0] code;
  logic        code_ready;
  logic        busy;
  logic [1:0]  class_id;
  logic        class_valid;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;

  logic [63:0] tmpl [4];
  int          m_score [4];
  int          snap [4];
  int          m_wait;
  int          m_frames;
  logic        m_dec_pending;
  logic [1:0]  m_class_id;

  code_classifier #(
    .NUM_CLASS(4),
    .NUM_FRAMES(8),
    .TEMPLATES({T3, T2, T1, T0})
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .code_valid(code_valid),
    .code(code),
    .code_ready(code_ready),
    .busy(busy),
    .class_id(class_id),
    .class_valid(class_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] modelArgmax();
    logic [1:0] best = 2'd0;
    for (int k = 1; k < 4; k++) if (m_score[k] > m_score[best]) best = 2'(k);
    return best;
  endfunction

  task automatic modelClear();
    for (int k = 0; k < 4; k++) m_score[k] = 0;
    m_wait = 0;
    m_frames = 0;
    m_dec_pending = 1'b0;
  endtask

  // Called at a negedge: checks outputs against the model, drives inputs, advances one cycle
  task automatic applyStimulus(input logic v, input logic [63:0] w, input logic c, output logic acc);
    logic exp_ready;
    logic exp_cv;
    if (m_wait > 0) m_wait--;
    exp_ready = (m_wait == 0);
    exp_cv = 1'b0;
    if (m_dec_pending && m_wait == 1) begin
      for (int k = 0; k < 4; k++) begin
        snap[k] = int'(dut.scores[k]);
        checkOutput("score", 64'(dut.scores[k]), 64'(m_score[k]));
      end
    end
    if (m_dec_pending && m_wait == 0) begin
      exp_cv = 1'b1;
      m_class_id = modelArgmax();
      for (int k = 0; k < 4; k++) m_score[k] = 0;
      m_dec_pending = 1'b0;
    end
    checkOutput("code_ready", 64'(code_ready), 64'(exp_ready));
    checkOutput("busy", 64'(busy), 64'(!exp_ready));
    checkOutput("class_valid", 64'(class_valid), 64'(exp_cv));
    checkOutput("class_id", 64'(class_id), 64'(m_class_id));
    if (class_valid) pulses++;
    acc = v && exp_ready && !c;
    if (acc) begin
      for (int k = 0; k < 4; k++) m_score[k] += $countones(~(w ^ tmpl[k]));
      m_frames++;
      if (m_frames == 8) begin
        m_wait = 6;
        m_dec_pending = 1'b1;
        m_frames = 0;
      end else begin
        m_wait = 5;
      end
    end
    if (c) modelClear();
    code_valid = v;
    code = w;
    clr = c;
    cyc++;
    @(negedge clk);
  endtask

  task automatic feedWord(input logic [63:0] w, output int at);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    at = cyc;
    while (!acc && n < 20) begin
      at = cyc;
      applyStimulus(1'b1, w, 1'b0, acc);
      n++;
    end
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idleCycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 64'h0, 1'b0, acc);
  endtask

  task automatic feedFrames(input logic [63:0] w, input int n);
    int at;
    for (int i = 0; i < n; i++) feedWord(w, at);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int at;
    int prev;
    logic acc;
    tmpl[0] = T0; tmpl[1] = T1; tmpl[2] = T2; tmpl[3] = T3;
    modelClear();
    m_class_id = 2'd0;
    rst_n = 1'b0;
    clr = 1'b0;
    code_valid = 1'b0;
    code = 64'h0;

    // Test 1: reset
    repeat (100) @(negedge clk);
    checkOutput("rst_class_id", 64'(class_id), 64'd0);
    checkOutput("rst_class_valid", 64'(class_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_code_ready", 64'(code_ready), 64'd1);
    @(negedge clk);

    // Test 2: single decision with code_valid held high
    pulses = 0;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      feedWord(T1, at);
      if (i > 0) checkOutput("accept_spacing", 64'(at - prev), 64'd5);
      prev = at;
    end
    idleCycles(8);
    checkOutput("t2_pulses", 64'(pulses), 64'd1);
    checkOutput("t2_class_id", 64'(class_id), 64'd1);
    checkOutput("t2_score0", 64'(snap[0]), 64'd0);
    checkOutput("t2_score1", 64'(snap[1]), 64'd512);
    checkOutput("t2_score2", 64'(snap[2]), 64'd256);
    checkOutput("t2_score3", 64'(snap[3]), 64'd256);

    // Test 3: tie-break
    feedFrames(64'h0000FFFFFFFF0000, 8);
    idleCycles(8);
    checkOutput("t3_tie_class_id", 64'(class_id), 64'd0);
    checkOutput("t3_tie_score", 64'(snap[3]), 64'd256);
    feedFrames(64'h00000000FFFFFFFF, 8);
    idleCycles(8);
    checkOutput("t3_class_id", 64'(class_id), 64'd2);

    // Test 4: clr abort after 5 words, then a clean decision
    feedFrames(T1, 5);
    applyStimulus(1'b1, T1, 1'b1, acc);
    pulses = 0;
    idleCycles(3);
    checkOutput("t4_no_pulse", 64'(pulses), 64'd0);
    checkOutput("t4_class_kept", 64'(class_id), 64'd2);
    feedFrames(64'hFFFFFFFF00000000, 8);
    idleCycles(8);
    checkOutput("t4_pulses", 64'(pulses), 64'd1);
    checkOutput("t4_class_id", 64'(class_id), 64'd3);

    // Test 5: back-pressure with a new word every cycle
    for (int i = 0; i < 150; i++) applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, acc);
    idleCycles(8);

    // Test 6: async reset during frame 3
    applyStimulus(1'b0, 64'h0, 1'b1, acc);
    feedFrames(T1, 3);
    idleCycles(1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_class_id", 64'(class_id), 64'd0);
    checkOutput("t6_class_valid", 64'(class_valid), 64'd0);
    checkOutput("t6_busy", 64'(busy), 64'd0);
    modelClear();
    m_class_id = 2'd0;
    pulses = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(6);
    checkOutput("t6_no_pulse", 64'(pulses), 64'd0);
    feedFrames(T2, 8);
    idleCycles(8);
    checkOutput("t6_pulses", 64'(pulses), 64'd1);
    checkOutput("t6_class_id", 64'(class_id), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
